// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo: change-compressed trace capture FIFO.
// Samples {in_data, in_sig} on enabled cycles and pushes a record only when
// it differs from the previous enabled sample (or is the first sample since
// reset). Records drain over a valid/ready stream. Records that arrive while
// the FIFO is full are dropped; overflow is sticky and drop_cnt saturates.
// Optional feature macro: TRACE_CAPTURE_TIMESTAMP_EN adds a 16-bit cycle
// counter, a per-record timestamp and the out_ts output port.
module trace_capture_fifo #(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned SIG_W  = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_en,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [SIG_W-1:0]           in_sig,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [SIG_W-1:0]           out_sig,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    ,
    output logic [15:0]                out_ts
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned REC_W = DATA_W + SIG_W;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    localparam int unsigned ENT_W = REC_W + 16;
`else
    localparam int unsigned ENT_W = REC_W;
`endif

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [REC_W-1:0]  prev_q, prev_d;
    logic              has_prev_q, has_prev_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [REC_W-1:0]  rec;
    logic [ENT_W-1:0]  wr_entry;
    logic [ENT_W-1:0]  head;
    logic              valid;
    logic              req;
    logic              push;
    logic              pop;
    logic              drop;

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    logic [15:0]       ts_q;

    // Free-running cycle counter, wraps naturally at 0xFFFF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_q + 16'd1;
    end

    assign wr_entry = {ts_q, rec};
`else
    assign wr_entry = rec;
`endif

    assign rec   = {in_data, in_sig};
    assign valid = (level_q != '0);
    assign pop   = valid && out_ready;
    assign req   = in_en && (!has_prev_q || (rec != prev_q));
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = req && ((level_q != LVL_W'(DEPTH)) || pop);
    assign drop  = req && !push;

    // Next-state for pointers, occupancy, change detector and drop tracking
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        prev_d     = prev_q;
        has_prev_d = has_prev_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (in_en) begin
            prev_d     = rec;
            has_prev_d = 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            prev_q     <= '0;
            has_prev_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage; contents are invalidated by level, so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_entry;
    end

    // Head outputs are forced to zero while empty so reset shows clean values
    assign head      = mem_q[rptr_q];
    assign out_valid = valid;
    assign out_data  = valid ? head[REC_W-1:SIG_W] : '0;
    assign out_sig   = valid ? head[SIG_W-1:0]     : '0;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    assign out_ts    = valid ? head[ENT_W-1:REC_W] : '0;
`endif
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
